psc_stream: RTL and testbench

PSC_STREAM -- requirements
Module: psc_stream

---
 rtl/psc_pkg.sv | 21 ++
 rtl/psc_stream_if.sv | 32 +++
 rtl/psc_lfsr.sv | 30 +++
 rtl/psc_stream.sv | 137 +++++++++++++
 tb/tb_psc_stream.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/psc_pkg.sv
// rtl/psc_pkg.sv - shared types and default constants for the psc_stream generator
package psc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_SUM = 2'd0,
        MODE_S1  = 2'd1,
        MODE_XOR = 2'd2,
        MODE_S2  = 2'd3
    } mode_t;

    localparam int         DEFAULT_W     = 9;
    localparam logic [8:0] DEFAULT_TAPS1 = 9'h003;
    localparam logic [8:0] DEFAULT_TAPS2 = 9'h00C;

endpackage

// File: rtl/psc_stream_if.sv
// rtl/psc_stream_if.sv - seed/sequence handshake bundle for psc_stream
// slave  : generator side (takes seed and control, drives seq_o/seq_valid_o/wrap_o/seed_ready_o)
// master : environment side (drives seed, enable, mode, width and seq_ready_i)
interface psc_stream_if
    import psc_pkg::*;
#(
    parameter int W = DEFAULT_W
);
    localparam int WW = $clog2(W + 1);

    logic [W-1:0]  seed_i;
    logic          seed_valid_i;
    logic          seed_ready_o;
    logic          en_i;
    logic [1:0]    mode_i;
    logic [WW-1:0] seq_width_i;
    logic [W-1:0]  seq_o;
    logic          seq_valid_o;
    logic          seq_ready_i;
    logic          wrap_o;

    modport slave (
        input  seed_i, seed_valid_i, en_i, mode_i, seq_width_i, seq_ready_i,
        output seed_ready_o, seq_o, seq_valid_o, wrap_o
    );

    modport master (
        output seed_i, seed_valid_i, en_i, mode_i, seq_width_i, seq_ready_i,
        input  seed_ready_o, seq_o, seq_valid_o, wrap_o
    );

endinterface

// File: rtl/psc_lfsr.sv
// rtl/psc_lfsr.sv - right-shifting Fibonacci LFSR with parallel load
// clk/resetn : clock, synchronous active-low reset (state cleared to zero)
// load       : load load_val (has priority over step)
// step       : advance one step, feedback = XOR-reduce(state & TAPS) into MSB
// state      : current register value
module psc_lfsr
    import psc_pkg::*;
#(
    parameter int           W    = DEFAULT_W,
    parameter logic [W-1:0] TAPS = W'(DEFAULT_TAPS1)
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         step,
    output logic [W-1:0] state
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= '0;
        end else if (load) begin
            state <= load_val;
        end else if (step) begin
            state <= {^(state & TAPS), state[W-1:1]};
        end
    end

endmodule

// File: rtl/psc_stream.sv
// rtl/psc_stream.sv - dual-LFSR sequence generator with seed handshake and backpressured output
// clk                   : sole clock, rising edge
// reproducible_button_n : synchronous active-low reset
// bus (slave)           : seed handshake, enable/mode/width controls, seq_o stream, wrap_o pulse
module psc_stream
    import psc_pkg::*;
#(
    parameter int           W     = DEFAULT_W,
    parameter logic [W-1:0] TAPS1 = W'(DEFAULT_TAPS1),
    parameter logic [W-1:0] TAPS2 = W'(DEFAULT_TAPS2)
) (
    input  logic         clk,
    input  logic         reproducible_button_n,
    psc_stream_if.slave  bus
);

    state_t       state_q, state_d;
    logic [W-1:0] seed_q, init_q, seq_q;
    logic         valid_q, fire_q;
    logic [W-1:0] s1, s2;
    logic [W-1:0] load_val, load_rev, comb_val, masked;
    logic         seed_ready, load, hs, fire;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reproducible_button_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (hs) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_RUN;
            ST_RUN:  if (hs) state_d = ST_LOAD;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        seed_ready = 1'b0;
        load       = 1'b0;
        case (state_q)
            ST_IDLE: seed_ready = 1'b1;
            ST_LOAD: load       = 1'b1;
            ST_RUN:  seed_ready = 1'b1;
            default: seed_ready = 1'b0;
        endcase
    end

    assign hs   = bus.seed_valid_i && seed_ready;
    // A seed handshake in RUN takes precedence over generating a word.
    assign fire = (state_q == ST_RUN) && bus.en_i && !hs && (!valid_q || bus.seq_ready_i);

    // A zero seed would lock the LFSR, so substitute all-ones.
    assign load_val = (seed_q == '0) ? '1 : seed_q;

    always_comb begin
        load_rev = '0;
        for (int i = 0; i < W; i++) begin
            load_rev[i] = load_val[W-1-i];
        end
    end

    always_comb begin
        comb_val = '0;
        case (mode_t'(bus.mode_i))
            MODE_SUM: comb_val = s1 + s2 + W'(bus.seq_width_i);
            MODE_S1:  comb_val = s1;
            MODE_XOR: comb_val = s1 ^ s2;
            MODE_S2:  comb_val = s2;
            default:  comb_val = '0;
        endcase
    end

    // Keep only the low seq_width_i bits; an out-of-range width gives zero.
    always_comb begin
        int wid;
        masked = '0;
        wid    = int'(bus.seq_width_i);
        if (wid <= W) begin
            for (int i = 0; i < W; i++) begin
                if (i < wid) masked[i] = comb_val[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reproducible_button_n) begin
            seed_q  <= '0;
            init_q  <= '0;
            seq_q   <= '0;
            valid_q <= 1'b0;
            fire_q  <= 1'b0;
        end else begin
            fire_q <= fire;
            if (hs)   seed_q <= bus.seed_i;
            if (load) init_q <= load_val;
            if (fire) begin
                seq_q   <= masked;
                valid_q <= 1'b1;
            end else if (hs || (state_q == ST_RUN && bus.seq_ready_i)) begin
                valid_q <= 1'b0;
            end
        end
    end

    psc_lfsr #(.W(W), .TAPS(TAPS1)) u_lfsr1 (
        .clk      (clk),
        .resetn   (reproducible_button_n),
        .load     (load),
        .load_val (load_val),
        .step     (fire),
        .state    (s1)
    );

    psc_lfsr #(.W(W), .TAPS(TAPS2)) u_lfsr2 (
        .clk      (clk),
        .resetn   (reproducible_button_n),
        .load     (load),
        .load_val (load_rev),
        .step     (fire),
        .state    (s2)
    );

    // s1 already holds the advanced value in the cycle after a fire.
    assign bus.wrap_o       = fire_q && (s1 == init_q);
    assign bus.seed_ready_o = seed_ready;
    assign bus.seq_o        = seq_q;
    assign bus.seq_valid_o  = valid_q;

endmodule

// File: tb/tb_psc_stream.sv
// tb/tb_psc_stream.sv - directed self-checking bench for psc_stream (W=9 and W=4 instances)
module tb_psc_stream;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   pulses;

    always #5 clk = ~clk;

    psc_stream_if #(.W(9)) b9 ();
    psc_stream_if #(.W(4)) b4 ();

    psc_stream #(.W(9)) dut9 (
        .clk                   (clk),
        .reproducible_button_n (rst_n),
        .bus                   (b9)
    );

    psc_stream #(.W(4), .TAPS1(4'h3), .TAPS2(4'hC)) dut4 (
        .clk                   (clk),
        .reproducible_button_n (rst_n),
        .bus                   (b4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        b9.seed_i       = '0;
        b9.seed_valid_i = 1'b0;
        b9.en_i         = 1'b0;
        b9.mode_i       = 2'd1;
        b9.seq_width_i  = 4'd9;
        b9.seq_ready_i  = 1'b1;
        b4.seed_i       = '0;
        b4.seed_valid_i = 1'b0;
        b4.en_i         = 1'b0;
        b4.mode_i       = 2'd1;
        b4.seq_width_i  = 3'd4;
        b4.seq_ready_i  = 1'b1;
        tick();
        tick();
        chk("rst_seq", 32'(b9.seq_o), 32'h0);
        chk("rst_valid", 32'(b9.seq_valid_o), 32'h0);
        chk("rst_wrap", 32'(b9.wrap_o), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("idle_ready", 32'(b9.seed_ready_o), 32'h1);

        // seed 1, mode 1, width 9
        b9.seed_i       = 9'h001;
        b9.seed_valid_i = 1'b1;
        b9.en_i         = 1'b1;
        tick();
        b9.seed_valid_i = 1'b0;
        chk("load_ready", 32'(b9.seed_ready_o), 32'h0);
        tick();
        chk("load_valid", 32'(b9.seq_valid_o), 32'h0);
        chk("run_ready", 32'(b9.seed_ready_o), 32'h1);
        tick();
        chk("w1", 32'(b9.seq_o), 32'h001);
        chk("w1_valid", 32'(b9.seq_valid_o), 32'h1);
        tick();
        chk("w2", 32'(b9.seq_o), 32'h100);
        tick();
        chk("w3", 32'(b9.seq_o), 32'h080);

        // combine modes and widths
        b9.mode_i = 2'd2;
        tick();
        chk("xor", 32'(b9.seq_o), 32'h060);
        b9.mode_i = 2'd3;
        tick();
        chk("s2", 32'(b9.seq_o), 32'h010);
        b9.mode_i = 2'd0;
        tick();
        chk("sum", 32'(b9.seq_o), 32'h021);
        b9.mode_i      = 2'd2;
        b9.seq_width_i = 4'd4;
        tick();
        chk("xor_w4", 32'(b9.seq_o), 32'h00C);
        b9.mode_i      = 2'd1;
        b9.seq_width_i = 4'd0;
        tick();
        chk("w0", 32'(b9.seq_o), 32'h000);
        b9.seq_width_i = 4'd10;
        tick();
        chk("w10", 32'(b9.seq_o), 32'h000);
        b9.seq_width_i = 4'd9;
        tick();
        chk("w9", 32'(b9.seq_o), 32'h101);

        // backpressure; mode changes while stalled must not disturb the held word
        b9.seq_ready_i = 1'b0;
        b9.mode_i      = 2'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_seq", 32'(b9.seq_o), 32'h101);
            chk("stall_valid", 32'(b9.seq_valid_o), 32'h1);
        end
        b9.mode_i      = 2'd1;
        b9.seq_ready_i = 1'b1;
        tick();
        chk("release1", 32'(b9.seq_o), 32'h180);
        tick();
        chk("release2", 32'(b9.seq_o), 32'h0C0);

        // reseed with zero while a fire would happen
        b9.seed_i       = 9'h000;
        b9.seed_valid_i = 1'b1;
        tick();
        b9.seed_valid_i = 1'b0;
        chk("reseed_valid", 32'(b9.seq_valid_o), 32'h0);
        chk("reseed_ready", 32'(b9.seed_ready_o), 32'h0);
        tick();
        chk("reload_valid", 32'(b9.seq_valid_o), 32'h0);
        tick();
        chk("zero_seed_w1", 32'(b9.seq_o), 32'h1FF);
        chk("zero_seed_valid", 32'(b9.seq_valid_o), 32'h1);
        tick();
        chk("zero_seed_w2", 32'(b9.seq_o), 32'h0FF);

        // one-cycle reset mid-run
        rst_n = 1'b0;
        tick();
        chk("mid_rst_seq", 32'(b9.seq_o), 32'h0);
        chk("mid_rst_valid", 32'(b9.seq_valid_o), 32'h0);
        chk("mid_rst_wrap", 32'(b9.wrap_o), 32'h0);
        rst_n    = 1'b1;
        b9.en_i  = 1'b0;
        tick();
        chk("post_rst_ready", 32'(b9.seed_ready_o), 32'h1);
        chk("post_rst_valid", 32'(b9.seq_valid_o), 32'h0);

        // W=4 wrap period
        b4.seed_i       = 4'h1;
        b4.seed_valid_i = 1'b1;
        b4.en_i         = 1'b1;
        tick();
        b4.seed_valid_i = 1'b0;
        tick();
        pulses = 0;
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (k == 1) chk("w4_first", 32'(b4.seq_o), 32'h1);
            chk($sformatf("wrap_k%0d", k), 32'(b4.wrap_o), ((k % 15) == 0) ? 32'h1 : 32'h0);
            if (b4.wrap_o) pulses++;
        end
        chk("wrap_pulses", 32'(pulses), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
